// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int DEF_TIMEOUT = 16;
  localparam int DEF_STARVE  = 4;

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} arb_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

  function automatic owner_t state_owner(input arb_state_t s);
    return (s == BUSY_IF) ? OWN_IF : OWN_DM;
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_hold.sv
// Load-enabled holding register for returned read data.
module unified_mem_arbiter_hold #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one single-port memory,
// with data priority, fetch anti-starvation and a per-transaction ack timeout.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter int STARVE_LIMIT   = DEF_STARVE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t    state, state_nxt;
  owner_t        grant, done;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic          mem_req_nxt, mem_we_nxt, err_nxt;
  logic [31:0]   mem_addr_nxt, mem_wdata_nxt, done_data;
  logic          if_elig, dm_elig;

  // A side whose valid is out this cycle cannot be re-issued in the same cycle.
  assign if_elig = if_req && !if_valid;
  assign dm_elig = dm_req && !dm_valid;

  always_comb begin
    state_nxt     = state;
    grant         = OWN_NONE;
    done          = OWN_NONE;
    done_data     = '0;
    tmo_nxt       = tmo_cnt;
    starve_nxt    = starve_cnt;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    err_nxt       = err;
    unique case (state)
      IDLE: begin
        // A held dm_req during its own valid cycle is a back-to-back request:
        // it still outranks fetch, so that cycle grants nobody unless starved.
        if (if_elig && (!dm_req || starve_cnt == STARVE_MAX)) grant = OWN_IF;
        else if (dm_elig)                                     grant = OWN_DM;
        if (grant == OWN_IF) begin
          state_nxt     = BUSY_IF;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = 1'b0;
          mem_addr_nxt  = if_addr;
          mem_wdata_nxt = '0;
          tmo_nxt       = '0;
          starve_nxt    = '0;
        end else if (grant == OWN_DM) begin
          state_nxt     = BUSY_DM;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = dm_we;
          mem_addr_nxt  = dm_addr;
          mem_wdata_nxt = dm_wdata;
          tmo_nxt       = '0;
          if (if_req && starve_cnt != STARVE_MAX) starve_nxt = starve_cnt + SW'(1);
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ack) begin
          state_nxt   = IDLE;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          done        = state_owner(state);
          done_data   = mem_we ? '0 : mem_rdata;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt   = IDLE;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          err_nxt     = 1'b1;
          done        = state_owner(state);
        end else begin
          tmo_nxt = tmo_cnt + TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      err        <= 1'b0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
    end else begin
      state      <= state_nxt;
      tmo_cnt    <= tmo_nxt;
      starve_cnt <= starve_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      err        <= err_nxt;
      if_valid   <= (done == OWN_IF);
      dm_valid   <= (done == OWN_DM);
    end
  end

  unified_mem_arbiter_hold #(.WIDTH(32)) u_if_hold (
    .clk  (clk),
    .rst  (rst),
    .load (done == OWN_IF),
    .d    (done_data),
    .q    (if_rdata)
  );

  unified_mem_arbiter_hold #(.WIDTH(32)) u_dm_hold (
    .clk  (clk),
    .rst  (rst),
    .load (done == OWN_DM),
    .d    (done_data),
    .q    (dm_rdata)
  );

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench: directed requester traffic, a programmable memory responder,
// and monitors checking memory requests and valid responses in order.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata;
  logic        if_valid, dm_valid;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        err;

  typedef struct { bit dm; logic [31:0] data; } rsp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } mreq_t;

  rsp_t        exp_rsp[$];
  mreq_t       exp_mem[$];
  logic [31:0] rdq[$];

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int ack_delay = 1;
  bit ack_en = 1'b1;
  int stray_tok = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Memory responder: checks each new request, acks ack_delay cycles after it.
  initial begin
    int    cnt = 0;
    int    stray_seen = 0;
    mreq_t m;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (stray_tok != stray_seen) begin
        stray_seen = stray_tok;
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
      end else if (mem_req) begin
        if (cnt == 0) begin
          if (exp_mem.size() == 0) chk("spurious_mem_req", 32'd1, 32'd0);
          else begin
            m = exp_mem.pop_front();
            chk("mem_we", {31'b0, mem_we}, {31'b0, m.we});
            chk("mem_addr", mem_addr, m.addr);
            chk("mem_wdata", mem_wdata, m.wdata);
          end
        end
        if (ack_en && cnt == ack_delay) begin
          mem_ack = 1'b1;
          mem_rdata = (rdq.size() != 0) ? rdq.pop_front() : 32'hDEADBEEF;
        end
        cnt++;
      end else begin
        cnt = 0;
      end
    end
  end

  // Response monitor.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (if_valid || dm_valid) begin
        if (exp_rsp.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
        else begin
          r = exp_rsp.pop_front();
          chk("valid_side", {31'b0, dm_valid}, {31'b0, r.dm});
          if (r.dm) chk("dm_rdata", dm_rdata, r.data);
          else      chk("if_rdata", if_rdata, r.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Returns negedge index (0 = issue cycle) of the valid pulse, -1 on timeout.
  task automatic wait_valid(input bit dm, output int n);
    n = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dm ? dm_valid : if_valid) begin
        n = i;
        break;
      end
    end
    if (n < 0) chk(dm ? "dm_valid_timeout" : "if_valid_timeout", 32'd1, 32'd0);
  endtask

  task automatic if_txn(input logic [31:0] addr, output int n);
    @(posedge clk); #1;
    if_addr = addr;
    if_req  = 1'b1;
    wait_valid(1'b0, n);
    if_req = 1'b0;
  endtask

  task automatic dm_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input int reps, output int n);
    @(posedge clk); #1;
    dm_we = we; dm_addr = addr; dm_wdata = wd;
    dm_req = 1'b1;
    for (int k = 0; k < reps; k++) wait_valid(1'b1, n);
    dm_req = 1'b0;
  endtask

  initial begin
    int nf, nd;
    rst = 1'b0;
    if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_valids", {30'b0, if_valid, dm_valid}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Fetch only, ack three cycles after mem_req.
    ack_delay = 3;
    exp_mem.push_back('{1'b0, 32'h100, 32'h0});
    rdq.push_back(32'h00500093);
    exp_rsp.push_back('{1'b0, 32'h00500093});
    if_txn(32'h100, nf);
    chk("fetch_latency", nf, 5);
    @(negedge clk);
    chk("if_valid_one_pulse", {31'b0, if_valid}, 32'd0);

    // Stray ack in IDLE must be ignored.
    stray_tok++;
    repeat (3) @(negedge clk);
    chk("stray_ack_no_req", {31'b0, mem_req}, 32'd0);
    chk("if_rdata_hold", if_rdata, 32'h00500093);

    // Simultaneous load and fetch: data first, fetch after dm_valid.
    ack_delay = 1;
    exp_mem.push_back('{1'b0, 32'h2000, 32'h0});
    exp_mem.push_back('{1'b0, 32'h104, 32'h0});
    rdq.push_back(32'h11112222);
    rdq.push_back(32'h00000013);
    exp_rsp.push_back('{1'b1, 32'h11112222});
    exp_rsp.push_back('{1'b0, 32'h00000013});
    fork
      dm_txn(1'b0, 32'h2000, 32'h0, 1, nd);
      if_txn(32'h104, nf);
    join
    chk("both_dm_latency", nd, 3);
    chk("both_if_latency", nf, 6);

    // Starvation: dm_req held for 5 loads, fetch gets the 5th grant.
    for (int k = 0; k < 4; k++) begin
      exp_mem.push_back('{1'b0, 32'h3000, 32'h0});
      rdq.push_back(32'hD0000001 + k);
      exp_rsp.push_back('{1'b1, 32'hD0000001 + k});
    end
    exp_mem.push_back('{1'b0, 32'h108, 32'h0});
    rdq.push_back(32'h0000F1F1);
    exp_rsp.push_back('{1'b0, 32'h0000F1F1});
    exp_mem.push_back('{1'b0, 32'h3000, 32'h0});
    rdq.push_back(32'hD0000005);
    exp_rsp.push_back('{1'b1, 32'hD0000005});
    fork
      dm_txn(1'b0, 32'h3000, 32'h0, 5, nd);
      if_txn(32'h108, nf);
    join
    chk("starve_if_latency", nf, 18);

    // Store: dm_rdata forced to zero regardless of mem_rdata.
    ack_delay = 2;
    exp_mem.push_back('{1'b1, 32'h40, 32'hCAFEF00D});
    rdq.push_back(32'h77777777);
    exp_rsp.push_back('{1'b1, 32'h0});
    dm_txn(1'b1, 32'h40, 32'hCAFEF00D, 1, nd);
    chk("store_latency", nd, 4);
    chk("if_rdata_hold_store", if_rdata, 32'h0000F1F1);

    // Timeout on a load with no ack.
    chk("err_before_tmo", {31'b0, err}, 32'd0);
    ack_en = 1'b0;
    exp_mem.push_back('{1'b0, 32'h500, 32'h0});
    exp_rsp.push_back('{1'b1, 32'h0});
    dm_txn(1'b0, 32'h500, 32'h0, 1, nd);
    chk("tmo_latency", nd, 17);
    chk("tmo_err", {31'b0, err}, 32'd1);
    chk("tmo_mem_req", {31'b0, mem_req}, 32'd0);
    ack_en = 1'b1;
    ack_delay = 1;
    exp_mem.push_back('{1'b0, 32'h10C, 32'h0});
    rdq.push_back(32'h00A00113);
    exp_rsp.push_back('{1'b0, 32'h00A00113});
    if_txn(32'h10C, nf);
    chk("err_sticky", {31'b0, err}, 32'd1);

    // Reset during BUSY_DM: outputs clear at once, no dm_valid afterwards.
    ack_en = 1'b0;
    exp_mem.push_back('{1'b0, 32'h600, 32'h0});
    @(posedge clk); #1;
    dm_we = 0; dm_addr = 32'h600; dm_req = 1'b1;
    repeat (4) @(negedge clk);
    chk("busy_before_rst", {31'b0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("arst_mem_addr", mem_addr, 32'd0);
    chk("arst_err", {31'b0, err}, 32'd0);
    chk("arst_rdata", if_rdata | dm_rdata, 32'd0);
    dm_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    ack_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_valid_after_rst", {31'b0, dm_valid | if_valid}, 32'd0);
    chk("rsp_queue_drained", exp_rsp.size(), 32'd0);
    chk("mem_queue_drained", exp_mem.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: cycles without mem_ack before a transaction is aborted.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: consecutive data grants allowed while fetch is pending.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port if_req  input  1  fetch request, held until if_valid is seen.
REQ-006 SHALL have port if_addr  input  32  fetch address, stable while if_req is high.
REQ-007 SHALL have port if_rdata  output  32  fetched instruction word.
REQ-008 SHALL have port if_valid  output  1  one-cycle pulse marking if_rdata valid.
REQ-009 SHALL have port dm_req  input  1  data request, held until dm_valid is seen.
REQ-010 SHALL have port dm_we  input  1  data write enable, qualified by dm_req.
REQ-011 SHALL have ports dm_addr and dm_wdata  input  32 each  data address and write data, stable while dm_req is high.
REQ-012 SHALL have port dm_rdata  output  32  load data.
REQ-013 SHALL have port dm_valid  output  1  one-cycle completion pulse for both loads and stores.
REQ-014 SHALL have ports mem_req, mem_we  output  1 each  single-port memory request and write enable.
REQ-015 SHALL have ports mem_addr, mem_wdata  output  32 each  memory address and write data.
REQ-016 SHALL have port mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-017 SHALL have port mem_ack  input  1  one-cycle completion pulse from memory, variable latency of at least 1 cycle.
REQ-018 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-019 SHALL implement the FSM states IDLE, BUSY_IF and BUSY_DM.
REQ-020 IDLE SHALL grant at most one requester per cycle and register mem_req/we/addr/wdata from the winner; mem_req rises the cycle after the grant decision.
REQ-021 Priority: data wins over fetch, except that fetch SHALL win when starve_cnt==STARVE_LIMIT and if_req is high.
REQ-022 starve_cnt SHALL increment on each data grant made while if_req is high, clear on any fetch grant, and saturate at STARVE_LIMIT.
REQ-023 A requester whose valid output is high in the current cycle SHALL be ineligible for grant in that cycle (no double-issue).
REQ-024 In BUSY_* state, mem_req and the mem_* outputs SHALL remain stable until the cycle mem_ack is high.
REQ-025 On mem_ack, the FSM SHALL drop mem_req and go to IDLE next cycle; in that same next cycle it SHALL pulse the granted side's valid and drive its rdata = registered mem_rdata (stores: dm_rdata = 0).
REQ-026 Minimum turnaround: grant decision -> mem_req high at cycle +1; ack at cycle +1 -> valid at cycle +2; next grant no earlier than the valid cycle.
REQ-027 A timeout counter SHALL clear on grant and increment each BUSY cycle; when it reaches TIMEOUT_CYCLES without ack, the block SHALL abort: drop mem_req, set err, pulse valid with rdata = 0, and return to IDLE.
REQ-028 mem_ack in IDLE SHALL be ignored.
REQ-029 rdata outputs SHALL hold their last value between valid pulses.

Reset
REQ-030 While rst is low: state = IDLE; mem_req, mem_we, if_valid, dm_valid and err = 0; mem_addr, mem_wdata, if_rdata and dm_rdata = 0; starve_cnt and the timeout counter = 0.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction with no valid pulse; only reset clears err.

Structure
REQ-032 The state enum arb_state_t, the default TIMEOUT and STARVE constants, and the grant-owner enum SHALL live in shared package mem_arb_pkg.
REQ-033 Returned-data holding SHALL reuse the existing register sub-module, with a 32-bit instance per side.

Verification
REQ-034 Fetch only: if_req=1, if_addr=0x100; mem_ack 3 cycles after mem_req with rdata=0x00500093 -> if_valid one pulse, if_rdata=0x00500093, mem_addr=0x100.
REQ-035 Simultaneous if_req and dm_req (load 0x2000) -> the data access is served first, fetch is granted only after dm_valid, and mem_req is never issued for both.
REQ-036 Starvation: dm_req held continuously with if_req high -> after 4 data grants the 5th grant goes to fetch.
REQ-037 Store: dm_we=1, dm_addr=0x40, dm_wdata=0xCAFEF00D -> mem_we=1 with matching addr/wdata; dm_valid pulses and dm_rdata=0.
REQ-038 Timeout: mem_ack never asserted -> after 16 BUSY cycles, mem_req drops, err=1, valid pulses with rdata=0, and err stays 1 until rst.
REQ-039 rst pulled low during BUSY_DM -> all outputs are 0 immediately (asynchronously), and no dm_valid pulse follows.
